// File: rtl/uart_oversample_rx.sv
// Oversampling UART receiver: synchronises uart_rxd, validates the start bit at
// mid-bit, shifts data LSB-first and classifies the stop bit into a good byte,
// a line break or a framing error, each reported as a one-cycle strobe.
module uart_oversample_rx #(
  parameter int unsigned CLK_HZ       = 25000000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_break,
  output logic                    uart_rx_frame_err
);

  localparam int unsigned CPB  = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB);
  localparam int unsigned BW   = $clog2(PAYLOAD_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                  state;
  logic                    rxd_meta;
  logic                    rxd_s;
  logic [CW-1:0]           cyc_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [PAYLOAD_BITS-1:0] shreg;

  // Two-flop synchroniser for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Receive FSM with counters, shift register and registered strobes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= IDLE;
      cyc_cnt           <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_break     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_data      <= '0;
    end else begin
      uart_rx_valid     <= 1'b0;
      uart_rx_break     <= 1'b0;
      uart_rx_frame_err <= 1'b0;

      if (state != IDLE && !uart_rx_en) begin
        // Disabling mid-frame drops the frame silently.
        state   <= IDLE;
        cyc_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            if (uart_rx_en && !rxd_s) begin
              state <= START;
            end
          end

          START: begin
            if (cyc_cnt == CW'(HALF - 1)) begin
              cyc_cnt <= '0;
              // A line that is high again at mid-bit was only a glitch.
              state   <= rxd_s ? IDLE : DATA;
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end

          DATA: begin
            if (cyc_cnt == CW'(CPB - 1)) begin
              cyc_cnt <= '0;
              shreg   <= (shreg >> 1) |
                         (PAYLOAD_BITS'(rxd_s) << (PAYLOAD_BITS - 1));
              if (bit_cnt == BW'(PAYLOAD_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end

          STOP: begin
            if (cyc_cnt == CW'(CPB - 1)) begin
              cyc_cnt <= '0;
              if (rxd_s) begin
                uart_rx_data  <= shreg;
                uart_rx_valid <= 1'b1;
                state         <= IDLE;
              end else if (shreg == '0) begin
                uart_rx_break <= 1'b1;
                state         <= WAIT_HIGH;
              end else begin
                uart_rx_frame_err <= 1'b1;
                state             <= WAIT_HIGH;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end

          WAIT_HIGH: begin
            // A line still held low must not be mistaken for a new start bit.
            if (rxd_s) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_oversample_rx.sv
// Scoreboard bench for uart_oversample_rx: the stimulus process drives serial
// frames and queues the response each frame should produce; the monitor
// process pops and compares whenever the receiver raises a strobe.
module tb_uart_oversample_rx;

  localparam int unsigned CLK_HZ   = 1600;
  localparam int unsigned BIT_RATE = 100;
  localparam int unsigned PB       = 8;
  localparam int unsigned CPB      = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF     = CPB / 2;
  // Line falls in cycle n: seen on rxd_s at n+2, stop sampled HALF+(PB+1)*CPB
  // later, strobe visible one cycle after that.
  localparam int unsigned LAT      = 2 + HALF + (PB + 1) * CPB + 1;

  localparam int K_VALID = 1;
  localparam int K_BREAK = 2;
  localparam int K_FERR  = 3;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned when;
  } exp_t;

  logic          clk;
  logic          resetn;
  logic          uart_rxd;
  logic          uart_rx_en;
  logic          uart_rx_valid;
  logic [PB-1:0] uart_rx_data;
  logic          uart_rx_break;
  logic          uart_rx_frame_err;

  exp_t        exp_q[$];
  int unsigned cyc;
  bit          done;
  int          n_total;
  int          n_pass;
  logic [7:0]  model_data;
  exp_t        e;
  int          n_strobes;
  int          got_kind;

  uart_oversample_rx #(
    .CLK_HZ      (CLK_HZ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PB)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .uart_rxd         (uart_rxd),
    .uart_rx_en       (uart_rx_en),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_break    (uart_rx_break),
    .uart_rx_frame_err(uart_rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 100000);
    $display("FAIL timeout: got no finish, want finish within 100000 cycles");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference classification of a frame from its data and stop bit.
  task automatic push_expect(input logic [7:0] d, input logic stop_bit, input int unsigned start);
    exp_t x;
    x.data = d;
    x.when = start + LAT;
    if (stop_bit)      x.kind = K_VALID;
    else if (d == 8'h00) x.kind = K_BREAK;
    else               x.kind = K_FERR;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    push_expect(d, stop_bit, cyc);
    uart_rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (CPB) tick();
    end
    uart_rxd = stop_bit;
    repeat (CPB) tick();
    uart_rxd = 1'b1;
  endtask

  // Frame interrupted during data bit 4: mode 0 pulses reset, mode 1 drops enable.
  task automatic send_aborted(input logic [7:0] d, input int mode);
    uart_rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      if (i == 3) begin
        repeat (4) tick();
        if (mode == 0) begin
          resetn = 1'b0;
          tick();
          resetn = 1'b1;
          repeat (CPB - 5) tick();
        end else begin
          uart_rx_en = 1'b0;
          repeat (CPB - 4) tick();
        end
      end else begin
        repeat (CPB) tick();
      end
    end
    uart_rxd = 1'b1;
    repeat (CPB) tick();
    uart_rx_en = 1'b1;
    repeat (4) tick();
  endtask

  // Stimulus: directed scenarios followed by randomized frames.
  initial begin
    logic [7:0] d;
    logic       sb;
    resetn     = 1'b0;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    done       = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (5) tick();

    send_frame(8'hA5, 1'b1);
    repeat (CPB) tick();

    uart_rxd = 1'b0;
    repeat (3) tick();
    uart_rxd = 1'b1;
    repeat (20) tick();
    send_frame(8'h3C, 1'b1);
    repeat (CPB) tick();

    push_expect(8'h00, 1'b0, cyc);
    uart_rxd = 1'b0;
    repeat (12 * CPB) tick();
    uart_rxd = 1'b1;
    repeat (2 * CPB) tick();
    send_frame(8'h01, 1'b1);
    repeat (CPB) tick();

    send_frame(8'h55, 1'b0);
    repeat (CPB) tick();
    send_frame(8'hFF, 1'b1);
    repeat (CPB) tick();

    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (CPB) tick();

    d = 8'hF8 | 8'($urandom_range(0, 7));
    send_aborted(d, 0);
    send_frame(8'hC3, 1'b1);
    repeat (CPB) tick();
    send_aborted(8'($urandom), 1);
    send_frame(8'hC3, 1'b1);
    repeat (CPB) tick();

    for (int n = 0; n < 40; n++) begin
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(d, sb);
      if (sb) repeat ($urandom_range(0, 2 * CPB)) tick();
      else    repeat (CPB + $urandom_range(0, CPB)) tick();
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    repeat (40) tick();
    done = 1'b1;
  end

  task automatic check(input bit ok, input string name, input longint got, input longint want);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Monitor: compares every strobe against the scoreboard and the held data.
  initial begin
    n_total    = 0;
    n_pass     = 0;
    model_data = 8'h00;
  end

  always @(negedge clk) begin
    if (done) begin
      check(exp_q.size() == 0, "pending_at_end", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end else begin
      n_strobes = int'(uart_rx_valid === 1'b1) + int'(uart_rx_break === 1'b1) +
                  int'(uart_rx_frame_err === 1'b1);
      if (resetn) check(n_strobes <= 1, "one_hot_strobes", n_strobes, 1);

      if (n_strobes != 0) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_strobe", n_strobes, 0);
        end else begin
          e = exp_q.pop_front();
          got_kind = uart_rx_valid ? K_VALID : (uart_rx_break ? K_BREAK : K_FERR);
          check(got_kind == e.kind, "strobe_kind", got_kind, e.kind);
          check(cyc == e.when, "strobe_cycle", cyc, e.when);
          if (e.kind == K_VALID) model_data = e.data;
        end
      end else if (exp_q.size() != 0 && exp_q[0].when < cyc) begin
        e = exp_q.pop_front();
        check(1'b0, "missed_strobe", 0, e.kind);
      end

      if (!resetn) model_data = 8'h00;
      else check(uart_rx_data === model_data, "rx_data", uart_rx_data, model_data);
    end
  end

endmodule
